// File: rtl/fixedp_pkg.sv
// Shared fixed-point types: default Q/N, output FSM states and the requester id type.
package fixedp_pkg;

   localparam int DEF_Q = 15;
   localparam int DEF_N = 32;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

   typedef logic req_id_t;

   localparam req_id_t REQ0 = 1'b0;
   localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/fixedp_add.sv
// Combinational sign-magnitude adder: saturates the magnitude to all-ones on carry
// out of the magnitude field when the operand signs agree.
module fixedp_add #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] c,
   output logic         sat
);

   logic         sign_a;
   logic         sign_b;
   logic [N-2:0] mag_a;
   logic [N-2:0] mag_b;
   logic [N-1:0] mag_sum;

   assign sign_a  = a[N-1];
   assign sign_b  = b[N-1];
   assign mag_a   = a[N-2:0];
   assign mag_b   = b[N-2:0];
   assign mag_sum = {1'b0, mag_a} + {1'b0, mag_b};

   // Unequal signs can never overflow; equal magnitudes keep a's sign.
   always_comb begin
      c   = '0;
      sat = 1'b0;
      if (sign_a == sign_b) begin
         if (mag_sum[N-1]) begin
            c   = {sign_a, {(N-1){1'b1}}};
            sat = 1'b1;
         end else begin
            c = {sign_a, mag_sum[N-2:0]};
         end
      end else if (mag_a > mag_b) begin
         c = {sign_a, mag_a - mag_b};
      end else if (mag_b > mag_a) begin
         c = {sign_b, mag_b - mag_a};
      end else begin
         c = {sign_a, {(N-1){1'b0}}};
      end
   end

endmodule

// File: rtl/fixedp_add_arb.sv
// Two-requester round-robin front end for one shared sign-magnitude adder with a
// single result register. Define FIXEDP_ADD_ARB_STATS_EN to add the sat_cnt output.
module fixedp_add_arb
   import fixedp_pkg::*;
#(
   parameter int Q = DEF_Q,
   parameter int N = DEF_N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_c,
   output logic         rsp_id,
   output logic         rsp_sat
`ifdef FIXEDP_ADD_ARB_STATS_EN
   ,output logic [15:0] sat_cnt
`endif
);

   if (Q < 0 || Q > N - 2) begin : g_bad_q
      $error("fixedp_add_arb: Q must lie in 0..N-2");
   end

   out_state_t   state;
   req_id_t      prio;
   req_id_t      grant_id;
   logic         can_accept;
   logic         grant0;
   logic         grant1;
   logic         accept;
   logic [N-1:0] op_a;
   logic [N-1:0] op_b;
   logic [N-1:0] sum_c;
   logic         sum_sat;

   assign can_accept = (state == ST_EMPTY) || rsp_ready;
   assign grant0     = req0_valid && (!req1_valid || prio == REQ0);
   assign grant1     = req1_valid && (!req0_valid || prio == REQ1);
   // rst_n gating keeps both readys low for the whole reset pulse.
   assign req0_ready = rst_n && can_accept && grant0;
   assign req1_ready = rst_n && can_accept && grant1;
   assign accept     = req0_ready || req1_ready;
   assign grant_id   = grant1 ? REQ1 : REQ0;
   assign op_a       = grant1 ? req1_a : req0_a;
   assign op_b       = grant1 ? req1_b : req0_b;
   assign rsp_valid  = (state == ST_FULL);

   fixedp_add #(
      .N (N)
   ) u_add (
      .a   (op_a),
      .b   (op_b),
      .c   (sum_c),
      .sat (sum_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_EMPTY;
         prio    <= REQ0;
         rsp_c   <= '0;
         rsp_id  <= REQ0;
         rsp_sat <= 1'b0;
      end else if (accept) begin
         state   <= ST_FULL;
         rsp_c   <= sum_c;
         rsp_id  <= grant_id;
         rsp_sat <= sum_sat;
         prio    <= (grant_id == REQ0) ? REQ1 : REQ0;
      end else if (rsp_ready) begin
         state <= ST_EMPTY;
      end
   end

`ifdef FIXEDP_ADD_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt <= '0;
      end else if (accept && sum_sat && sat_cnt != 16'hFFFF) begin
         sat_cnt <= sat_cnt + 16'd1;
      end
   end
`endif

endmodule
